monitor_link: RTL and testbench

- Host-side initiator for the UART load/dump/exec monitor protocol.
- Takes one command at a time and serializes it to a UART transmitter as three header bytes plus payload: addr_hi, addr_lo, then {op[1:0], len[5:0]}.
- Checks every byte echoed back by the far-end monitor, and streams dump data out.
- Sits between a command source (test sequencer or second FPGA) and a uart core instance.

---
 rtl/monitor_link.sv | 223 ++++++++++++++++++++++
 tb/tb_monitor_link.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_link.sv
// monitor_link: host-side initiator for the UART load/dump/exec monitor protocol.
// Serializes one command as addr_hi, addr_lo, {op,len} plus any load payload,
// checks every echoed byte, and streams dump bytes back out to the host.
module monitor_link #(
  parameter int TIMEOUT = 2400000,
  parameter int CW      = 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [5:0]  cmd_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [7:0]  tx_byte,
  output logic        transmit,
  input  logic        is_transmitting,
  input  logic [7:0]  rx_byte,
  input  logic        received,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    ECHO,
    LOADW,
    DUMPR
  } state_t;

  localparam logic [1:0]    OP_LOAD     = 2'd1;
  localparam logic [1:0]    OP_EXEC     = 2'd3;
  localparam logic [1:0]    HDR_OPLEN   = 2'd2;
  localparam logic [1:0]    HDR_PAYLOAD = 2'd3;
  localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT - 1);

  state_t        state, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [1:0]    op_q, op_d;
  logic [5:0]    len_q, len_d;
  logic [1:0]    hdr_idx, hdr_idx_d;
  logic [5:0]    remaining, remaining_d;
  logic [7:0]    exp_byte, exp_byte_d;
  logic [7:0]    wr_byte, wr_byte_d;
  logic [CW-1:0] tmo_cnt, tmo_cnt_d;
  logic [7:0]    tx_byte_d, rd_data_d;
  logic          transmit_d, rd_valid_d, wr_ready_d, done_d, error_d;
  logic [7:0]    send_byte;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Pick the next outgoing byte: three header bytes, then the latched payload byte.
  always_comb begin
    send_byte = wr_byte;
    case (hdr_idx)
      2'd0:    send_byte = addr_q[15:8];
      2'd1:    send_byte = addr_q[7:0];
      2'd2:    send_byte = {op_q, len_q};
      default: send_byte = wr_byte;
    endcase
  end

  // Next-state and next-output decode; all pulse outputs default low every cycle.
  always_comb begin
    state_d     = state;
    addr_d      = addr_q;
    op_d        = op_q;
    len_d       = len_q;
    hdr_idx_d   = hdr_idx;
    remaining_d = remaining;
    exp_byte_d  = exp_byte;
    wr_byte_d   = wr_byte;
    tmo_cnt_d   = tmo_cnt;
    tx_byte_d   = tx_byte;
    rd_data_d   = rd_data;
    transmit_d  = 1'b0;
    rd_valid_d  = 1'b0;
    wr_ready_d  = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          op_d      = cmd_op;
          len_d     = cmd_len;
          hdr_idx_d = 2'd0;
          if (cmd_op == 2'd0) begin
            error_d = 1'b1;
          end else begin
            state_d = SEND;
          end
        end
      end

      SEND: begin
        if (!is_transmitting) begin
          tx_byte_d  = send_byte;
          transmit_d = 1'b1;
          exp_byte_d = send_byte;
          tmo_cnt_d  = '0;
          state_d    = ECHO;
        end
      end

      ECHO: begin
        if (received) begin
          tmo_cnt_d = '0;
          if (rx_byte != exp_byte) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else if (hdr_idx < HDR_OPLEN) begin
            hdr_idx_d = hdr_idx + 2'd1;
            state_d   = SEND;
          end else if (hdr_idx == HDR_OPLEN) begin
            hdr_idx_d   = HDR_PAYLOAD;
            remaining_d = len_q;
            if (op_q == OP_EXEC || len_q == 6'd0) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else if (op_q == OP_LOAD) begin
              state_d = LOADW;
            end else begin
              state_d = DUMPR;
            end
          end else begin
            remaining_d = remaining - 6'd1;
            if (remaining == 6'd1) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = LOADW;
            end
          end
        end else if (tmo_cnt == TMO_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
        end
      end

      LOADW: begin
        if (wr_valid) begin
          wr_ready_d = 1'b1;
          wr_byte_d  = wr_data;
          state_d    = SEND;
        end
      end

      DUMPR: begin
        // done is held back one cycle after the last rd_valid so the pulses never overlap
        if (remaining == 6'd0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (received) begin
          rd_data_d   = rx_byte;
          rd_valid_d  = 1'b1;
          remaining_d = remaining - 6'd1;
          tmo_cnt_d   = '0;
        end else if (tmo_cnt == TMO_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any command in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      op_q      <= '0;
      len_q     <= '0;
      hdr_idx   <= '0;
      remaining <= '0;
      exp_byte  <= '0;
      wr_byte   <= '0;
      tmo_cnt   <= '0;
      tx_byte   <= '0;
      rd_data   <= '0;
      transmit  <= 1'b0;
      rd_valid  <= 1'b0;
      wr_ready  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      len_q     <= len_d;
      hdr_idx   <= hdr_idx_d;
      remaining <= remaining_d;
      exp_byte  <= exp_byte_d;
      wr_byte   <= wr_byte_d;
      tmo_cnt   <= tmo_cnt_d;
      tx_byte   <= tx_byte_d;
      rd_data   <= rd_data_d;
      transmit  <= transmit_d;
      rd_valid  <= rd_valid_d;
      wr_ready  <= wr_ready_d;
      done      <= done_d;
      error     <= error_d;
    end
  end

endmodule

// File: tb/tb_monitor_link.sv
// tb_monitor_link: drives monitor_link through a far-end monitor/UART model and
// compares every transaction against a protocol-level reference model.
`timescale 1ns/1ps
module tb_monitor_link;

  localparam int TMO        = 100;
  localparam int CMD_BUDGET = 5000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [5:0]  cmd_len;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [7:0]  tx_byte;
  logic        transmit;
  logic        is_transmitting;
  logic [7:0]  rx_byte;
  logic        received;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  monitor_link #(.TIMEOUT(TMO), .CW(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .wr_data         (wr_data),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .tx_byte         (tx_byte),
    .transmit        (transmit),
    .is_transmitting (is_transmitting),
    .rx_byte         (rx_byte),
    .received        (received),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [5:0]  len;
    logic [23:0] data;
    int          corrupt_idx;
    bit          silent;
    int          exp_ntx;
    logic [39:0] exp_tx;
    int          exp_nrd;
    int          exp_wr;
    int          exp_done;
    int          exp_error;
  } vec_t;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] stim_pay[64];
  logic [7:0] stim_dump[64];

  logic [7:0] obs_tx[$];
  logic [7:0] obs_rd[$];
  int obs_wr, obs_done, obs_error, obs_overlap, obs_ready_after;
  int first_tx_cyc, error_cyc;

  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rd_q[$];
  int exp_wr, exp_done, exp_error;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_compared++;
    if (actual !== required) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
    end
  endtask

  function automatic vec_t mkVec(input string name, input logic [1:0] op, input logic [15:0] addr,
                                 input logic [5:0] len, input logic [23:0] data, input int corrupt_idx,
                                 input bit silent, input int exp_ntx, input logic [39:0] exp_tx,
                                 input int exp_nrd, input int exp_wr, input int exp_done, input int exp_error);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.len = len; v.data = data;
    v.corrupt_idx = corrupt_idx; v.silent = silent; v.exp_ntx = exp_ntx; v.exp_tx = exp_tx;
    v.exp_nrd = exp_nrd; v.exp_wr = exp_wr; v.exp_done = exp_done; v.exp_error = exp_error;
    return v;
  endfunction

  // Issue one command and play the far-end monitor: echo every transmitted byte
  // (optionally corrupting one, or staying silent) and stream dump data after the header.
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] addr, input logic [5:0] len,
                               input int corrupt_idx, input bit silent, input int abort_after_rd,
                               input bit stall);
    logic [7:0] rxq[$];
    logic [7:0] echo;
    int rx_wait, tx_busy, wr_idx, cyc, end_cyc;
    bit finished;
    obs_tx.delete(); obs_rd.delete();
    obs_wr = 0; obs_done = 0; obs_error = 0; obs_overlap = 0; obs_ready_after = 0;
    first_tx_cyc = -1; error_cyc = -1;
    rx_wait = 0; tx_busy = 0; wr_idx = 0; cyc = 0; end_cyc = 0; finished = 0;
    @(negedge clk);
    received = 1'b0; is_transmitting = 1'b0; wr_valid = 1'b0;
    checkOutput("cmd_ready_at_issue", {31'd0, cmd_ready}, 32'd1);
    cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b0;
      received  = 1'b0;
      if ((int'(done) + int'(error) + int'(rd_valid) + int'(wr_ready)) > 1) obs_overlap++;
      if (rd_valid) obs_rd.push_back(rd_data);
      if (wr_ready) begin obs_wr++; wr_idx++; end
      if (done) obs_done++;
      if (error) begin obs_error++; if (error_cyc < 0) error_cyc = cyc; end
      if (finished && cyc == end_cyc + 1 && cmd_ready && !busy) obs_ready_after = 1;
      if (tx_busy > 0) begin
        tx_busy--;
        if (tx_busy == 0) is_transmitting = 1'b0;
      end
      if (rx_wait > 0) begin
        rx_wait--;
        if (rx_wait == 0 && rxq.size() > 0) begin
          rx_byte  = rxq.pop_front();
          received = 1'b1;
          if (rxq.size() > 0) rx_wait = $urandom_range(1, 4);
        end
      end
      if (transmit) begin
        obs_tx.push_back(tx_byte);
        if (first_tx_cyc < 0) first_tx_cyc = cyc;
        is_transmitting = 1'b1;
        tx_busy = $urandom_range(1, 4);
        if (!silent) begin
          echo = tx_byte;
          if (obs_tx.size() - 1 == corrupt_idx) echo = tx_byte ^ 8'h01;
          rxq.push_back(echo);
          if (op == 2'd2 && obs_tx.size() == 3 && echo == tx_byte)
            for (int i = 0; i < int'(len); i++) rxq.push_back(stim_dump[i]);
          rx_wait = $urandom_range(1, 6);
        end
      end
      wr_valid = (op == 2'd1 && wr_idx < int'(len)) && (!stall || $urandom_range(0, 2) != 0);
      wr_data  = stim_pay[wr_idx % 64];
      if (!finished && (done || error)) begin finished = 1; end_cyc = cyc; end
      if (finished && cyc >= end_cyc + 6) break;
      if (abort_after_rd >= 0 && obs_rd.size() == abort_after_rd) break;
      if (cyc >= CMD_BUDGET) begin
        n_compared++; n_mismatched++;
        $display("[TB] FAIL cycle_budget: command still busy after %0d cycles, required done or error", cyc);
        break;
      end
    end
    wr_valid = 1'b0;
  endtask

  // Reference model: the byte stream and pulse counts implied by the protocol rules.
  task automatic modelExpect(input logic [1:0] op, input logic [15:0] addr, input logic [5:0] len,
                             input int corrupt_idx, input bit silent);
    logic [7:0] full[$];
    exp_tx_q.delete(); exp_rd_q.delete();
    exp_wr = 0; exp_done = 0; exp_error = 0;
    if (op == 2'd0) begin exp_error = 1; return; end
    full.push_back(addr[15:8]);
    full.push_back(addr[7:0]);
    full.push_back({op, len});
    if (op == 2'd1) for (int i = 0; i < int'(len); i++) full.push_back(stim_pay[i]);
    if (silent) begin exp_tx_q.push_back(full[0]); exp_error = 1; return; end
    if (corrupt_idx >= 0 && corrupt_idx < full.size()) begin
      for (int i = 0; i <= corrupt_idx; i++) exp_tx_q.push_back(full[i]);
      exp_error = 1;
    end else begin
      exp_tx_q = full;
      exp_done = 1;
      if (op == 2'd2) for (int i = 0; i < int'(len); i++) exp_rd_q.push_back(stim_dump[i]);
    end
    if (op == 2'd1 && exp_tx_q.size() > 3) exp_wr = exp_tx_q.size() - 3;
  endtask

  task automatic checkCommon(input string tag);
    checkOutput({tag, "/pulse_overlap"}, obs_overlap, 0);
    checkOutput({tag, "/idle_after_end"}, obs_ready_after, 1);
  endtask

  task automatic verifyModel(input string tag);
    checkOutput({tag, "/tx_count"}, obs_tx.size(), exp_tx_q.size());
    for (int i = 0; i < exp_tx_q.size() && i < obs_tx.size(); i++)
      checkOutput($sformatf("%s/tx[%0d]", tag, i), obs_tx[i], exp_tx_q[i]);
    checkOutput({tag, "/rd_count"}, obs_rd.size(), exp_rd_q.size());
    for (int i = 0; i < exp_rd_q.size() && i < obs_rd.size(); i++)
      checkOutput($sformatf("%s/rd[%0d]", tag, i), obs_rd[i], exp_rd_q[i]);
    checkOutput({tag, "/wr_ready_count"}, obs_wr, exp_wr);
    checkOutput({tag, "/done_count"}, obs_done, exp_done);
    checkOutput({tag, "/error_count"}, obs_error, exp_error);
    checkCommon(tag);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "/tx_byte"}, tx_byte, 0);
    checkOutput({tag, "/transmit"}, transmit, 0);
    checkOutput({tag, "/rd_data"}, rd_data, 0);
    checkOutput({tag, "/rd_valid"}, rd_valid, 0);
    checkOutput({tag, "/wr_ready"}, wr_ready, 0);
    checkOutput({tag, "/done"}, done, 0);
    checkOutput({tag, "/error"}, error, 0);
    checkOutput({tag, "/busy"}, busy, 0);
    checkOutput({tag, "/cmd_ready"}, cmd_ready, 1);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [15:0] r_addr;
    logic [5:0]  r_len;
    int          r_corrupt;
    bit          r_silent;
    int          total;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; is_transmitting = 1'b0; rx_byte = '0; received = 1'b0;
    for (int i = 0; i < 64; i++) begin stim_pay[i] = '0; stim_dump[i] = '0; end

    #23;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    vecs[0] = mkVec("load",     2'd1, 16'h0012, 6'd2, 24'hA55A00, -1, 0, 5, 40'h001242A55A, 0, 2, 1, 0);
    vecs[1] = mkVec("dump",     2'd2, 16'h0012, 6'd2, 24'hA55A00, -1, 0, 3, 40'h0012820000, 2, 0, 1, 0);
    vecs[2] = mkVec("exec",     2'd3, 16'h0000, 6'd0, 24'h000000, -1, 0, 3, 40'h0000C00000, 0, 0, 1, 0);
    vecs[3] = mkVec("mismatch", 2'd1, 16'h0012, 6'd2, 24'hA55A00,  1, 0, 2, 40'h0012000000, 0, 0, 0, 1);
    vecs[4] = mkVec("timeout",  2'd1, 16'h0012, 6'd2, 24'hA55A00, -1, 1, 1, 40'h0000000000, 0, 0, 0, 1);
    vecs[5] = mkVec("bad_op",   2'd0, 16'h1234, 6'd4, 24'h000000, -1, 0, 0, 40'h0000000000, 0, 0, 0, 1);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 3; i++) begin
        stim_pay[i]  = vecs[v].data[23 - 8*i -: 8];
        stim_dump[i] = vecs[v].data[23 - 8*i -: 8];
      end
      applyStimulus(vecs[v].op, vecs[v].addr, vecs[v].len, vecs[v].corrupt_idx, vecs[v].silent, -1, 0);
      checkOutput({vecs[v].name, "/tx_count"}, obs_tx.size(), vecs[v].exp_ntx);
      for (int i = 0; i < vecs[v].exp_ntx && i < obs_tx.size(); i++)
        checkOutput($sformatf("%s/tx[%0d]", vecs[v].name, i), obs_tx[i], vecs[v].exp_tx[39 - 8*i -: 8]);
      checkOutput({vecs[v].name, "/rd_count"}, obs_rd.size(), vecs[v].exp_nrd);
      for (int i = 0; i < vecs[v].exp_nrd && i < obs_rd.size(); i++)
        checkOutput($sformatf("%s/rd[%0d]", vecs[v].name, i), obs_rd[i], vecs[v].data[23 - 8*i -: 8]);
      checkOutput({vecs[v].name, "/wr_ready_count"}, obs_wr, vecs[v].exp_wr);
      checkOutput({vecs[v].name, "/done_count"}, obs_done, vecs[v].exp_done);
      checkOutput({vecs[v].name, "/error_count"}, obs_error, vecs[v].exp_error);
      checkCommon(vecs[v].name);
      if (vecs[v].silent)
        checkOutput({vecs[v].name, "/latency"}, error_cyc - first_tx_cyc, TMO);
    end

    // Reset in the middle of a 3-byte dump, after the first byte has streamed out.
    stim_dump[0] = 8'h11; stim_dump[1] = 8'h22; stim_dump[2] = 8'h33;
    applyStimulus(2'd2, 16'h0034, 6'd3, -1, 0, 1, 0);
    checkOutput("mid_dump/rd_count_before_reset", obs_rd.size(), 1);
    if (obs_rd.size() > 0) checkOutput("mid_dump/rd0", obs_rd[0], 8'h11);
    #2 rst_n = 1'b0;
    #1 checkResetOutputs("mid_dump_reset");
    @(negedge clk);
    received = 1'b0; is_transmitting = 1'b0; rx_byte = '0; wr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelExpect(2'd3, 16'h0100, 6'd5, -1, 0);
    applyStimulus(2'd3, 16'h0100, 6'd5, -1, 0, -1, 0);
    verifyModel("exec_after_reset");

    // Randomized commands against the reference model.
    for (int n = 0; n < 40; n++) begin
      r_op      = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      r_addr    = 16'($urandom);
      r_len     = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 5)) : 6'($urandom_range(0, 63));
      r_silent  = ($urandom_range(0, 19) == 0);
      total     = 3 + ((r_op == 2'd1) ? int'(r_len) : 0);
      r_corrupt = ($urandom_range(0, 4) == 0) ? $urandom_range(0, total - 1) : -1;
      for (int i = 0; i < 64; i++) begin
        stim_pay[i]  = 8'($urandom);
        stim_dump[i] = 8'($urandom);
      end
      modelExpect(r_op, r_addr, r_len, r_corrupt, r_silent);
      applyStimulus(r_op, r_addr, r_len, r_corrupt, r_silent, -1, 1);
      verifyModel($sformatf("rand%0d", n));
      if (r_silent && r_op != 2'd0)
        checkOutput($sformatf("rand%0d/latency", n), error_cyc - first_tx_cyc, TMO);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
